// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner and whatever drives and observes it:
// start/s_in in, vector, status and truth table out.
interface truth_table_scanner_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic                 s_in;
  logic [N_IN-1:0]      vec_out;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        ones_cnt;
`ifdef GOLDEN_CHECK_EN
  logic [2**N_IN-1:0]   expected;
  logic                 mismatch;
  logic [N_IN-1:0]      fail_idx;
`endif

  modport master (
    output start, s_in,
`ifdef GOLDEN_CHECK_EN
    output expected,
    input  mismatch, fail_idx,
`endif
    input  vec_out, busy, done,
    input  table_out, ones_cnt
  );

  modport slave (
    input  start, s_in,
`ifdef GOLDEN_CHECK_EN
    input  expected,
    output mismatch, fail_idx,
`endif
    output vec_out, busy, done,
    output table_out, ones_cnt
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks all 2^N_IN vectors into a combinational function and records its truth table.
// Optional GOLDEN_CHECK_EN compares the table against a reference latched on start.
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_scanner_if.slave bus
);
  localparam int W = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [3:0] LOAD =
    4'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [N_IN-1:0] vec;
  logic [W-1:0]    tbl, tbl_nxt;
  logic [N_IN:0]   ones;
  logic            accept;
  logic            last;

  assign accept = (state == S_IDLE) && bus.start;
  assign last   = (vec == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.start)
          state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      S_SETTLE:
        if (cnt == 4'd0) state_nxt = S_SAMPLE;
      S_SAMPLE:
        if (last)             state_nxt = S_DONE;
        else if (SETTLE == 0) state_nxt = S_SAMPLE;
        else                  state_nxt = S_SETTLE;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tbl_nxt      = tbl;
    tbl_nxt[vec] = bus.s_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      vec  <= '0;
      tbl  <= '0;
      ones <= '0;
    end else if (accept) begin
      cnt  <= LOAD;
      vec  <= '0;
      tbl  <= '0;
      ones <= '0;
    end else if (state == S_SETTLE) begin
      cnt <= cnt - 4'd1;
    end else if (state == S_SAMPLE) begin
      tbl  <= tbl_nxt;
      ones <= ones + (N_IN+1)'(bus.s_in);
      if (!last) begin
        vec <= vec + 1'b1;
        cnt <= LOAD;
      end
    end
  end

  assign bus.vec_out   = vec;
  assign bus.table_out = tbl;
  assign bus.ones_cnt  = ones;
  assign bus.busy      = (state == S_SETTLE) ||
                         (state == S_SAMPLE);
  assign bus.done      = (state == S_DONE);

`ifdef GOLDEN_CHECK_EN
  logic [W-1:0]    gold;
  logic [W-1:0]    diff;
  logic [N_IN-1:0] idx;
  logic            mis;
  logic [N_IN-1:0] fidx;

  assign diff = tbl_nxt ^ gold;

  // Downward sweep leaves the lowest differing index.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (diff[i]) idx = N_IN'(i);
  end

  // Result is registered as DONE is entered so it is valid during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold <= '0;
      mis  <= 1'b0;
      fidx <= '0;
    end else if (accept) begin
      gold <= bus.expected;
      mis  <= 1'b0;
      fidx <= '0;
    end else if (state == S_SAMPLE && last) begin
      mis  <= |diff;
      fidx <= idx;
    end
  end

  assign bus.mismatch = mis;
  assign bus.fail_idx = fidx;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: three instances (SETTLE 1/0/2)
// with a queue scoreboard filled on start and drained on done.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_IN(3)) ia();
  truth_table_scanner_if #(.N_IN(3)) ib();
  truth_table_scanner_if #(.N_IN(3)) ic();

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  truth_table_scanner #(.N_IN(3), .SETTLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));
  truth_table_scanner #(.N_IN(3), .SETTLE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave));

  logic       st[3];
  logic [1:0] mode[3];
  logic       dn[3];
  logic       bz[3];
  logic [7:0] to[3];
  logic [3:0] oc[3];
  logic [2:0] vo[3];

  // mode 0: s = ~(x & ~y) & z, mode 1: const 1, mode 2: const 0
  function automatic logic fn(logic [1:0] m, logic [2:0] v);
    case (m)
      2'd0:    return ~(v[2] & ~v[1]) & v[0];
      2'd1:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] model(logic [1:0] m);
    logic [7:0] t;
    logic [2:0] v;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      t[i] = fn(m, v);
    end
    return t;
  endfunction

  assign ia.start = st[0];
  assign ib.start = st[1];
  assign ic.start = st[2];
  assign ia.s_in = fn(mode[0], ia.vec_out);
  assign ib.s_in = fn(mode[1], ib.vec_out);
  assign ic.s_in = fn(mode[2], ic.vec_out);
  assign dn[0] = ia.done;
  assign dn[1] = ib.done;
  assign dn[2] = ic.done;
  assign bz[0] = ia.busy;
  assign bz[1] = ib.busy;
  assign bz[2] = ic.busy;
  assign to[0] = ia.table_out;
  assign to[1] = ib.table_out;
  assign to[2] = ic.table_out;
  assign oc[0] = ia.ones_cnt;
  assign oc[1] = ib.ones_cnt;
  assign oc[2] = ic.ones_cnt;
  assign vo[0] = ia.vec_out;
  assign vo[1] = ib.vec_out;
  assign vo[2] = ic.vec_out;

`ifdef GOLDEN_CHECK_EN
  logic [7:0] gold = 8'h00;
  assign ia.expected = gold;
  assign ib.expected = 8'h00;
  assign ic.expected = 8'h00;
`endif

  logic [7:0] exp_q[$];
  int         lat_q[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(int sel, logic [1:0] m, bit retrig);
    int         n;
    int         el;
    int         pulses;
    logic [7:0] et;
    int         sv;
    sv = (sel == 0) ? 1 : (sel == 1) ? 0 : 2;
    mode[sel] = m;
    exp_q.push_back(model(m));
    lat_q.push_back(8 * (sv + 1));
    @(negedge clk);
    st[sel] = 1'b1;
    @(posedge clk);
    #1;
    st[sel] = 1'b0;
    n = 0;
    pulses = 0;
    while (!dn[sel] && n < 100) begin
      if (sel == 2) chk("vec_walk", 32'(vo[2]), n / 3);
      st[sel] = retrig && (n == 3 || n == 9);
      @(posedge clk);
      #1;
      n++;
    end
    st[sel] = 1'b0;
    et = exp_q.pop_front();
    el = lat_q.pop_front();
    chk("latency", n, el);
    chk("table", 32'(to[sel]), 32'(et));
    chk("ones", 32'(oc[sel]), $countones(et));
    chk("busy_done", 32'(bz[sel]), 0);
    @(posedge clk);
    #1;
    if (dn[sel]) pulses++;
    chk("done_pulse", pulses, 0);
    chk("vec_hold", 32'(vo[sel]), 7);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      mode[i] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", 32'(vo[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_table", 32'(to[0]), 0);
    chk("rst_ones", 32'(oc[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 2'd0, 1'b0);
    chk("fxyz_table", 32'(to[0]), 32'h8A);
    chk("fxyz_ones", 32'(oc[0]), 3);

    run(1, 2'd1, 1'b0);
    chk("ones_all", 32'(oc[1]), 8);
    run(1, 2'd2, 1'b0);

    run(2, 2'd0, 1'b0);

    run(0, 2'd0, 1'b1);
    chk("retrig_table", 32'(to[0]), 32'h8A);

    @(negedge clk);
    mode[0] = 2'd1;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_vec", 32'(vo[0]), 0);
    chk("abort_busy", 32'(bz[0]), 0);
    chk("abort_done", 32'(dn[0]), 0);
    chk("abort_table", 32'(to[0]), 0);
    chk("abort_ones", 32'(oc[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(dn[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 2'd0, 1'b0);

`ifdef GOLDEN_CHECK_EN
    gold = 8'h8A;
    run(0, 2'd0, 1'b0);
    chk("gold_match", 32'(ia.mismatch), 0);
    chk("gold_idx0", 32'(ia.fail_idx), 0);
    gold = 8'h8E;
    run(0, 2'd0, 1'b0);
    chk("gold_mis", 32'(ia.mismatch), 1);
    chk("gold_idx", 32'(ia.fail_idx), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
